// File: rtl/gelu_pkg.sv
// Shared definitions for the GELU sequencer: state encoding, FP16 constants
// and the default datapath latency.
package gelu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_FIN   = 3'd5
  } gelu_seq_state_t;

  localparam logic [15:0] FP16_ONE     = 16'h3C00;
  localparam logic [15:0] FP16_HALF    = 16'h3800;
  localparam int          GELU_LAT_DEF = 5;

endpackage

// File: rtl/gelu_seq_ctrl.sv
// One-element-at-a-time sequencer: scratchpad read -> GELU datapath -> scratchpad write.
// Optional cycle counter output perf_cycles when GELU_SEQ_PERF_EN is defined.
module gelu_seq_ctrl
  import gelu_pkg::*;
#(
  parameter int GELU_LAT = GELU_LAT_DEF,
  parameter int AW       = 12,
  parameter int LW       = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic [LW-1:0] len,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [15:0]   rd_data,
  output logic          gelu_valid,
  output logic [15:0]   gelu_in,
  input  logic [15:0]   gelu_result,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  input  logic          wr_ready,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] elem_cnt
`ifdef GELU_SEQ_PERF_EN
  ,
  output logic [31:0]   perf_cycles
`endif
);

  localparam int WCW = (GELU_LAT > 1) ? $clog2(GELU_LAT) : 1;

  gelu_seq_state_t state_q, state_d;
  logic [AW-1:0]   src_q, src_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   idx_q, idx_d;
  logic [LW-1:0]   elem_cnt_q, elem_cnt_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic            rd_en_q, rd_en_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic            gelu_valid_q, gelu_valid_d;
  logic [15:0]     gelu_in_q, gelu_in_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]     wr_data_q, wr_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            start_acc;

  // abort has priority over start even in IDLE
  assign start_acc = (state_q == ST_IDLE) && start && !abort;

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    idx_d        = idx_q;
    elem_cnt_d   = elem_cnt_q;
    wcnt_d       = wcnt_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    gelu_valid_d = 1'b0;
    gelu_in_d    = gelu_in_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          src_d      = src_base;
          dst_d      = dst_base;
          len_d      = len;
          idx_d      = '0;
          elem_cnt_d = '0;
          if (len == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d   = ST_READ;
            rd_en_d   = 1'b1;
            rd_addr_d = src_base;
          end
        end
      end
      ST_READ: state_d = ST_LOAD;
      ST_LOAD: begin
        gelu_in_d    = rd_data;
        gelu_valid_d = 1'b1;
        wcnt_d       = WCW'(GELU_LAT - 1);
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        if (wcnt_q == '0) begin
          wr_data_d = gelu_result;
          wr_addr_d = dst_q + AW'(idx_q);
          wr_en_d   = 1'b1;
          state_d   = ST_WRITE;
        end else begin
          wcnt_d = wcnt_q - WCW'(1);
        end
      end
      ST_WRITE: begin
        if (wr_ready) begin
          idx_d      = idx_q + LW'(1);
          elem_cnt_d = elem_cnt_q + LW'(1);
          if (idx_d == len_q) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_READ;
            rd_en_d   = 1'b1;
            rd_addr_d = src_q + AW'(idx_d);
          end
        end else begin
          wr_en_d = 1'b1;
        end
      end
      ST_FIN: begin
        // a zero-length job enters FIN without done set, so it spends one extra cycle here
        if (done_q) state_d = ST_IDLE;
        else        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE) && (state_q != ST_FIN)) begin
      state_d      = ST_FIN;
      done_d       = 1'b1;
      rd_en_d      = 1'b0;
      gelu_valid_d = 1'b0;
      wr_en_d      = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      elem_cnt_q   <= '0;
      wcnt_q       <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      gelu_valid_q <= 1'b0;
      gelu_in_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      elem_cnt_q   <= elem_cnt_d;
      wcnt_q       <= wcnt_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      gelu_valid_q <= gelu_valid_d;
      gelu_in_q    <= gelu_in_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign gelu_valid = gelu_valid_q;
  assign gelu_in    = gelu_in_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign elem_cnt   = elem_cnt_q;

`ifdef GELU_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (start_acc)                      perf_d = '0;
    else if (busy_q && (perf_q != '1))  perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: doc/gelu_seq_ctrl.md
# gelu_seq_ctrl

Sequencer that streams a vector of FP16 activations from the input scratchpad through the GELU datapath and writes the results to the output scratchpad. The GELU datapath is not a fully pipelined unit: its input register must stay stable until the result emerges. This block therefore issues one element at a time, waits the fixed datapath latency, captures the result and writes it back. It sits between the accelerator command decoder (start/config) and the `gelu` unit plus two SRAM ports.

## Interface
- `GELU_LAT`, 5, cycles from `gelu_valid` high to a valid `gelu_result`.
- `AW`, 12, scratchpad address width.
- `LW`, 12, length counter width (maximum vector length 2^LW−1).
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; accepted only in IDLE.
- `abort` in 1: level; forces return to IDLE.
- `src_base` in AW: first input address.
- `dst_base` in AW: first output address.
- `len` in LW: number of elements.
- `rd_en` out 1: input SRAM read strobe.
- `rd_addr` out AW: input SRAM address.
- `rd_data` in 16: FP16 operand, valid one cycle after `rd_en`.
- `gelu_valid` out 1: drives the datapath load enable (`bn_valid`).
- `gelu_in` out 16: operand to the datapath.
- `gelu_result` in 16: datapath `final_result`.
- `wr_en` out 1: output SRAM write request.
- `wr_addr` out AW: output address.
- `wr_data` out 16: result.
- `wr_ready` in 1: write accepted when high together with `wr_en`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on completion or abort.
- `elem_cnt` out LW: elements written so far in the current job.

## Operation
- States: IDLE, READ, LOAD, WAIT, WRITE, FIN.
- IDLE: on `start`, latch `src_base`, `dst_base` and `len`, and clear `elem_cnt`. If `len==0` go to FIN, otherwise go to READ.
- READ: assert `rd_en` for one cycle with `rd_addr = src + idx`, then go to LOAD.
- LOAD: drive `gelu_in = rd_data`, assert `gelu_valid` for one cycle, load the wait counter with `GELU_LAT−1`, then go to WAIT.
- WAIT: decrement the counter each cycle. `gelu_valid` stays low so the datapath input register holds. At 0, capture `gelu_result` into the `wr_data` register and go to WRITE.
- WRITE: hold `wr_en` high with stable address and data until `wr_ready`.
  - On acceptance, increment `idx` and `elem_cnt`.
  - If `idx+1 == len`, go to FIN; otherwise go to READ.
- FIN: pulse `done` and go to IDLE.
- `abort` in any non-IDLE state:
  - Go to FIN next cycle and drop `rd_en`, `gelu_valid` and `wr_en` immediately.
  - A write in progress is not counted unless `wr_ready` is high in that same cycle.
- `start` while busy is ignored. `start` and `abort` in the same IDLE cycle: `abort` wins and no job starts.
- Address arithmetic is modulo 2^AW; wrap is silent.
- `gelu_in` holds its last value outside LOAD.

## Timing
- Reset values: state IDLE; `rd_en`, `gelu_valid`, `wr_en`, `busy`, `done` = 0; `rd_addr`, `wr_addr`, `wr_data`, `gelu_in`, `elem_cnt` = 0.
- All outputs are registered.
- Per element with `wr_ready` tied high: READ 1 + LOAD 1 + WAIT `GELU_LAT` + WRITE 1 = `GELU_LAT+3` cycles (8 by default).
- A job of N elements has `done` N·(GELU_LAT+3)+1 cycles after the `start` cycle.
- A job with `len==0` has `done` 2 cycles after `start`.
- `busy` rises the cycle after `start` and falls the cycle after `done`.
- Each cycle that `wr_ready` stays low extends WRITE by one cycle.

## Configuration
- `GELU_SEQ_PERF_EN` defined:
  - Adds output `perf_cycles` [31:0], which counts cycles while `busy`.
  - Cleared on an accepted `start`, saturates at all-ones, and holds after `done`.
- Not defined: the port and counter are absent and behaviour is otherwise identical.

## Structure
- Shared package `gelu_pkg`:
  - State enum `gelu_seq_state_t`.
  - FP16 constants `FP16_ONE=16'h3C00` and `FP16_HALF=16'h3800`.
  - Default `GELU_LAT`.
- Single module with no sub-modules. The wait counter is an inline down-counter of width $clog2(GELU_LAT).

## Test plan
- `len=1`, `rd_data=16'h3C00`, `wr_ready=1` -> exactly one `gelu_valid` pulse; one write at `dst_base` of the value sampled from `gelu_result` 5 cycles later; `done` at cycle 9.
- `len=4`, `src_base=12'h010`, `dst_base=12'h200` -> reads 0x010–0x013 and writes 0x200–0x203 in order; `elem_cnt=4`; no overlapping `gelu_valid` pulses.
- `len=0` -> no `rd_en`, `gelu_valid` or `wr_en`; `done` 2 cycles after `start`.
- `wr_ready` held low 3 cycles on element 2 -> `wr_addr` and `wr_data` stable throughout; total latency +3.
- `abort` asserted during WAIT of element 3 of 8 -> `done` next cycle; `elem_cnt=2`; no further SRAM traffic; a following `start` runs normally.
- `src_base=12'hFFE`, `len=3` -> `rd_addr` 0xFFE, 0xFFF, 0x000; `rst` pulsed mid-job -> all outputs return to their reset values immediately.
